// File: rtl/wb_rr_arbiter2.sv
// Two-master, single-slave Wishbone arbiter with round-robin fairness.
// A per-access watchdog ends a hung slave access with a dummy ack and a sticky flag.
module wb_rr_arbiter2 #(
  parameter int          adr_width    = 32,
  parameter int          timeout      = 255,
  parameter logic [31:0] timeout_data = 32'hFFFFFFFF
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  output logic [31:0]          m0_dat_o,
  input  logic [3:0]           m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  output logic                 m0_ack_o,

  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m1_dat_o,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  output logic                 m1_ack_o,

  output logic [adr_width-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [31:0]          s_dat_i,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic                 s_ack_i,

  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(timeout - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_last;      // 1 = m1 was served last
  logic                   r_last_nxt;
  logic [15:0]            r_cnt;
  logic                   r_to_pend;   // dummy-ack cycle in progress
  logic                   r_timeout;

  logic                   w_g_cyc;
  logic                   w_g_stb;
  logic [adr_width-1:0]   w_g_adr;
  logic [31:0]            w_g_dat;
  logic [3:0]             w_g_sel;
  logic                   w_g_we;
  logic                   w_wait;
  logic                   w_stay;
  logic                   w_expire;
  logic                   w_ack;
  logic [31:0]            w_rdat;

  // Next-state and round-robin bookkeeping
  always_comb begin
    w_next     = r_state;
    r_last_nxt = r_last;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next = r_last ? G0 : G1;
        end else if (m0_cyc_i) begin
          w_next = G0;
        end else if (m1_cyc_i) begin
          w_next = G1;
        end else begin
          w_next = IDLE;
        end
      end
      G0: begin
        if (!m0_cyc_i) begin
          w_next     = IDLE;
          r_last_nxt = 1'b0;
        end else begin
          w_next = G0;
        end
      end
      G1: begin
        if (!m1_cyc_i) begin
          w_next     = IDLE;
          r_last_nxt = 1'b1;
        end else begin
          w_next = G1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Granted-master request mux; idle drives all zeros
  always_comb begin
    w_g_cyc = 1'b0;
    w_g_stb = 1'b0;
    w_g_adr = '0;
    w_g_dat = 32'h0000_0000;
    w_g_sel = 4'h0;
    w_g_we  = 1'b0;
    case (r_state)
      G0: begin
        w_g_cyc = m0_cyc_i;
        w_g_stb = m0_stb_i;
        w_g_adr = m0_adr_i;
        w_g_dat = m0_dat_i;
        w_g_sel = m0_sel_i;
        w_g_we  = m0_we_i;
      end
      G1: begin
        w_g_cyc = m1_cyc_i;
        w_g_stb = m1_stb_i;
        w_g_adr = m1_adr_i;
        w_g_dat = m1_dat_i;
        w_g_sel = m1_sel_i;
        w_g_we  = m1_we_i;
      end
      default: begin
        w_g_cyc = 1'b0;
      end
    endcase
  end

  // A slave ack in the last allowed cycle beats the watchdog.
  assign w_wait   = w_g_cyc & w_g_stb & ~s_ack_i & ~r_to_pend;
  assign w_stay   = (w_next == r_state) && (r_state != IDLE);
  assign w_expire = w_wait & w_stay & (r_cnt == TO_LAST);

  // State, fairness pointer, watchdog and sticky flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_cnt     <= 16'd0;
      r_to_pend <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_last    <= r_last_nxt;
      r_to_pend <= w_expire;
      if (!w_stay || !w_wait || (r_cnt == TO_LAST)) begin
        r_cnt <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign s_cyc_o = w_g_cyc & ~r_to_pend;
  assign s_stb_o = w_g_stb & ~r_to_pend;
  assign s_adr_o = w_g_adr;
  assign s_dat_o = w_g_dat;
  assign s_sel_o = w_g_sel;
  assign s_we_o  = w_g_we;

  assign w_ack  = r_to_pend | s_ack_i;
  assign w_rdat = r_to_pend ? timeout_data : s_dat_i;

  assign m0_ack_o = (r_state == G0) & w_ack;
  assign m1_ack_o = (r_state == G1) & w_ack;
  assign m0_dat_o = (r_state == G0) ? w_rdat : 32'h0000_0000;
  assign m1_dat_o = (r_state == G1) ? w_rdat : 32'h0000_0000;

  assign grant_o   = r_state;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Directed self-checking bench for wb_rr_arbiter2 (watchdog shortened to 8 cycles).
module tb_wb_rr_arbiter2;

  logic        clk;
  logic        reset;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;
  logic exp_w;

  wb_rr_arbiter2 #(.adr_width(32), .timeout(8), .timeout_data(32'hFFFFFFFF)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tot++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    reset = 1'b1;
    m0_adr_i = 32'h0; m0_dat_i = 32'h0; m0_sel_i = 4'h0; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = 32'h0; m1_dat_i = 32'h0; m1_sel_i = 4'h0; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i = 32'h0; s_ack_i = 1'b0;
    #2;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_scyc", 32'(s_cyc_o), 32'd0);
    chk("rst_sstb", 32'(s_stb_o), 32'd0);
    chk("rst_ack0", 32'(m0_ack_o), 32'd0);
    chk("rst_ack1", 32'(m1_ack_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    tick; tick;
    reset = 1'b0;

    // m0 single read, slave acks on the third strobe cycle
    m0_adr_i = 32'h10; m0_sel_i = 4'hF; m0_we_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    #1;
    chk("t1_pre_grant", 32'(grant_o), 32'd0);
    chk("t1_pre_stb", 32'(s_stb_o), 32'd0);
    tick;
    chk("t1_grant", 32'(grant_o), 32'd1);
    chk("t1_sadr", s_adr_o, 32'h10);
    chk("t1_ssel", 32'(s_sel_o), 32'hF);
    chk("t1_sstb", 32'(s_stb_o), 32'd1);
    chk("t1_noack", 32'(m0_ack_o), 32'd0);
    tick; tick;
    s_ack_i = 1'b1; s_dat_i = 32'h12345678;
    #1;
    chk("t1_ack0", 32'(m0_ack_o), 32'd1);
    chk("t1_dat0", m0_dat_o, 32'h12345678);
    chk("t1_ack1", 32'(m1_ack_o), 32'd0);
    chk("t1_dat1", m1_dat_o, 32'h0);
    tick;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    #1;
    chk("t1_scyc_drop", 32'(s_cyc_o), 32'd0);
    tick;
    chk("t1_idle", 32'(grant_o), 32'd0);

    // Simultaneous writes; m0 was served last so m1 wins first
    m0_we_i = 1'b1; m1_we_i = 1'b1; m0_adr_i = 32'h100; m1_adr_i = 32'h200;
    m0_dat_i = 32'hA0; m1_dat_i = 32'hB1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    exp_w = 1'b1;
    for (int r = 0; r < 4; r++) begin
      #1;
      chk("t2_bubble", 32'(grant_o), 32'd0);
      tick;
      chk("t2_grant", 32'(grant_o), exp_w ? 32'd2 : 32'd1);
      chk("t2_sadr", s_adr_o, exp_w ? 32'h200 : 32'h100);
      chk("t2_sdat", s_dat_o, exp_w ? 32'hB1 : 32'hA0);
      chk("t2_swe", 32'(s_we_o), 32'd1);
      s_ack_i = 1'b1;
      #1;
      chk("t2_win_ack", 32'(exp_w ? m1_ack_o : m0_ack_o), 32'd1);
      chk("t2_lose_ack", 32'(exp_w ? m0_ack_o : m1_ack_o), 32'd0);
      tick;
      s_ack_i = 1'b0;
      if (exp_w) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
      else begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
      tick;
      if (r < 3) begin
        if (exp_w) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
        else begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
      end else begin
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      end
      exp_w = ~exp_w;
    end

    // m0 4-beat burst while m1 waits
    m0_we_i = 1'b0; m1_we_i = 1'b0; m0_adr_i = 32'h300; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick;
    m1_adr_i = 32'h999; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m0_adr_i = 32'h300 + 32'(4 * k); s_ack_i = 1'b1;
      #1;
      chk("t3_sadr", s_adr_o, 32'h300 + 32'(4 * k));
      chk("t3_grant", 32'(grant_o), 32'd1);
      chk("t3_m1ack", 32'(m1_ack_o), 32'd0);
      tick;
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    #1;
    chk("t3_hold", 32'(grant_o), 32'd1);
    tick;
    chk("t3_bubble", 32'(grant_o), 32'd0);
    tick;
    chk("t3_g1", 32'(grant_o), 32'd2);
    chk("t3_sadr1", s_adr_o, 32'h999);
    s_ack_i = 1'b1;
    #1;
    chk("t3_ack1", 32'(m1_ack_o), 32'd1);
    chk("t3_ack0", 32'(m0_ack_o), 32'd0);
    tick;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    tick;

    // Slave acks exactly in the last allowed wait cycle
    m0_adr_i = 32'h400; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("t5_wait", 32'(m0_ack_o), 32'd0);
      tick;
    end
    s_ack_i = 1'b1; s_dat_i = 32'hCAFEF00D;
    #1;
    chk("t5_ack", 32'(m0_ack_o), 32'd1);
    chk("t5_dat", m0_dat_o, 32'hCAFEF00D);
    chk("t5_sstb", 32'(s_stb_o), 32'd1);
    tick;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    #1;
    chk("t5_nopulse", 32'(m0_ack_o), 32'd0);
    chk("t5_noflag", 32'(timeout_o), 32'd0);
    tick;

    // Slave never acks: watchdog ends the access
    m0_adr_i = 32'h500; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t4_wait_ack", 32'(m0_ack_o), 32'd0);
      chk("t4_wait_stb", 32'(s_stb_o), 32'd1);
      tick;
    end
    s_ack_i = 1'b1; s_dat_i = 32'h55555555;
    #1;
    chk("t4_pulse_ack", 32'(m0_ack_o), 32'd1);
    chk("t4_pulse_dat", m0_dat_o, 32'hFFFFFFFF);
    chk("t4_pulse_stb", 32'(s_stb_o), 32'd0);
    chk("t4_pulse_cyc", 32'(s_cyc_o), 32'd0);
    chk("t4_pulse_grant", 32'(grant_o), 32'd1);
    tick;
    s_ack_i = 1'b0;
    #1;
    chk("t4_one_pulse", 32'(m0_ack_o), 32'd0);
    chk("t4_flag", 32'(timeout_o), 32'd1);
    chk("t4_stb_back", 32'(s_stb_o), 32'd1);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick;
    chk("t4_flag_idle", 32'(timeout_o), 32'd1);
    m0_adr_i = 32'h600; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick;
    s_ack_i = 1'b1; s_dat_i = 32'h0BADBEEF;
    #1;
    chk("t4_norm_dat", m0_dat_o, 32'h0BADBEEF);
    chk("t4_flag_sticky", 32'(timeout_o), 32'd1);
    tick;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    tick;

    // Reset in the middle of an m1 burst
    m1_adr_i = 32'h700; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick;
    s_ack_i = 1'b1;
    #1;
    chk("t6_beat1", 32'(m1_ack_o), 32'd1);
    tick;
    m1_adr_i = 32'h704;
    #1;
    chk("t6_beat2", 32'(m1_ack_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_grant", 32'(grant_o), 32'd0);
    chk("t6_scyc", 32'(s_cyc_o), 32'd0);
    chk("t6_sstb", 32'(s_stb_o), 32'd0);
    chk("t6_ack1", 32'(m1_ack_o), 32'd0);
    chk("t6_ack0", 32'(m0_ack_o), 32'd0);
    chk("t6_flag", 32'(timeout_o), 32'd0);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    tick; tick;
    reset = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    #1;
    chk("t6_bubble", 32'(grant_o), 32'd0);
    tick;
    chk("t6_m0_first", 32'(grant_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
